simd_warp_issuer: RTL and testbench

// - Upstream feeder of the SIMD stage. Accepts one warp descriptor (wid, block/accum offsets, inst count).
// - Steps pc 0..n_inst-1 and issues one instruction token per pc on the inst rdy/ack channel that the SIMD stage consumes.
// - Throttles issue with a credit counter of uncommitted instructions, refilled by the SIMD inst_commit pulse.
// - Reports warp completion once every issued instruction has committed.

---
 rtl/simd_warp_issuer_pkg.sv | 13 +
 rtl/simd_warp_issuer_credit.sv | 48 ++++
 rtl/simd_warp_issuer.sv | 117 +++++++++++
 tb/tb_simd_warp_issuer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/simd_warp_issuer_pkg.sv
// simd_warp_issuer_pkg: shared configuration for the SIMD warp issuer slice.
`default_nettype none

package simd_warp_issuer_pkg;

  localparam int TAU_N_INST   = 8;
  localparam int TAU_MAX_WARP = 8;
  localparam int TAU_VDIM     = 2;
  localparam int TAU_WORK_BW  = 8;

endpackage

`default_nettype wire

// File: rtl/simd_warp_issuer_credit.sv
// simd_credit_counter: tracks issued-but-uncommitted instructions, flags a commit seen with none outstanding.
`default_nettype none

module simd_credit_counter #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CRD_BW       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic next_empty,
  output logic err
);

  logic [CRD_BW-1:0] count;
  logic [CRD_BW-1:0] count_nxt;
  logic              underflow;

  always_comb begin
    count_nxt = count;
    underflow = 1'b0;
    if (inc && !dec) begin
      count_nxt = count + 1'b1;
    end else if (dec && !inc) begin
      // A commit with nothing outstanding is dropped rather than wrapping the count.
      if (count == '0) underflow = 1'b1;
      else             count_nxt = count - 1'b1;
    end
  end

  assign full       = (count == CRD_BW'(MAX_INFLIGHT));
  assign next_empty = (count_nxt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      if (underflow) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/simd_warp_issuer.sv
// simd_warp_issuer: accepts a warp descriptor, issues one token per pc under credit throttling,
// then reports completion once every issued instruction has committed.
`default_nettype none

module simd_warp_issuer
  import simd_warp_issuer_pkg::*;
#(
  parameter  int N_INST       = TAU_N_INST,
  parameter  int MAX_WARP     = TAU_MAX_WARP,
  parameter  int VDIM         = TAU_VDIM,
  parameter  int WBW          = TAU_WORK_BW,
  parameter  int MAX_INFLIGHT = 4,
  localparam int INST_BW      = $clog2(N_INST + 1),
  localparam int WID_BW       = $clog2(MAX_WARP)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_warp_rdy,
  output logic                      o_warp_ack,
  input  logic [WID_BW-1:0]         i_warp_wid,
  input  logic [VDIM-1:0][WBW-1:0]  i_warp_bofs,
  input  logic [VDIM-1:0][WBW-1:0]  i_warp_aofs,
  input  logic [INST_BW-1:0]        i_warp_ninst,
  output logic                      o_inst_rdy,
  input  logic                      i_inst_ack,
  output logic [INST_BW-1:0]        o_pc,
  output logic [WID_BW-1:0]         o_wid,
  output logic [VDIM-1:0][WBW-1:0]  o_bofs,
  output logic [VDIM-1:0][WBW-1:0]  o_aofs,
  input  logic                      i_commit_dval,
  output logic                      o_done_rdy,
  input  logic                      i_done_ack,
  output logic [WID_BW-1:0]         o_done_wid,
  output logic                      o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [INST_BW-1:0] ninst;
  logic               warp_xfer;
  logic               inst_xfer;
  logic               crd_full;
  logic               crd_next_empty;

  // Ack is masked during reset so a descriptor is never acknowledged and then lost.
  assign o_warp_ack = i_rst && (state == S_IDLE) && i_warp_rdy;
  assign warp_xfer  = o_warp_ack;
  assign o_inst_rdy = (state == S_ISSUE) && !crd_full;
  assign inst_xfer  = o_inst_rdy && i_inst_ack;
  assign o_done_rdy = (state == S_DONE);
  assign o_done_wid = o_wid;

  simd_credit_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .inc        (inst_xfer),
    .dec        (i_commit_dval),
    .full       (crd_full),
    .next_empty (crd_next_empty),
    .err        (o_err)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= S_IDLE;
      o_pc  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (warp_xfer) begin
            o_pc  <= '0;
            state <= (i_warp_ninst != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          // pc parks at ninst-1 after the last token instead of stepping past the program.
          if (inst_xfer) begin
            if (o_pc == ninst - INST_BW'(1)) state <= S_DRAIN;
            else                             o_pc  <= o_pc + 1'b1;
          end
        end
        S_DRAIN: begin
          if (crd_next_empty) state <= S_DONE;
        end
        S_DONE: begin
          if (i_done_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ninst  <= '0;
      o_wid  <= '0;
      o_bofs <= '0;
      o_aofs <= '0;
    end else if (warp_xfer) begin
      ninst  <= i_warp_ninst;
      o_wid  <= i_warp_wid;
      o_bofs <= i_warp_bofs;
      o_aofs <= i_warp_aofs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_warp_issuer.sv
// tb_simd_warp_issuer: directed scenarios plus randomized traffic checked against a counting model.
`default_nettype none

module tb_simd_warp_issuer;

  localparam int N_INST       = 8;
  localparam int INST_BW      = 4;
  localparam int WID_BW       = 3;
  localparam int MAX_INFLIGHT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                i_rst, i_warp_rdy, o_warp_ack;
  logic [WID_BW-1:0]   i_warp_wid, o_wid, o_done_wid;
  logic [1:0][7:0]     i_warp_bofs, i_warp_aofs, o_bofs, o_aofs;
  logic [INST_BW-1:0]  i_warp_ninst, o_pc;
  logic                o_inst_rdy, i_inst_ack, i_commit_dval;
  logic                o_done_rdy, i_done_ack, o_err;

  simd_warp_issuer dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_warp_rdy    (i_warp_rdy),
    .o_warp_ack    (o_warp_ack),
    .i_warp_wid    (i_warp_wid),
    .i_warp_bofs   (i_warp_bofs),
    .i_warp_aofs   (i_warp_aofs),
    .i_warp_ninst  (i_warp_ninst),
    .o_inst_rdy    (o_inst_rdy),
    .i_inst_ack    (i_inst_ack),
    .o_pc          (o_pc),
    .o_wid         (o_wid),
    .o_bofs        (o_bofs),
    .o_aofs        (o_aofs),
    .i_commit_dval (i_commit_dval),
    .o_done_rdy    (o_done_rdy),
    .i_done_ack    (i_done_ack),
    .o_done_wid    (o_done_wid),
    .o_err         (o_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a warp is a count of tokens issued against a count of uncommitted ones.
  bit          m_active = 0, m_drain = 0, m_done = 0, m_err = 0;
  int          m_issued = 0, m_ninst = 0, m_out = 0;
  int          m_wid = 0;
  logic [15:0] m_bofs = '0, m_aofs = '0;

  int          d_ninst = 0, d_wid = 0;
  logic [15:0] d_bofs = '0, d_aofs = '0;

  bit obs_wack, obs_irdy, obs_done, obs_err, last_wack;
  int obs_pc, obs_wid, obs_done_wid;

  task automatic step(input bit rst, input bit wrdy, input bit iack, input bit cmt, input bit dack);
    bit e_wack, e_irdy, e_iss;
    int nout;
    @(negedge clk);
    i_rst         = rst;
    i_warp_rdy    = wrdy;
    i_warp_wid    = d_wid[WID_BW-1:0];
    i_warp_ninst  = d_ninst[INST_BW-1:0];
    i_warp_bofs   = d_bofs;
    i_warp_aofs   = d_aofs;
    i_inst_ack    = iack;
    i_commit_dval = cmt;
    i_done_ack    = dack;
    #1;
    e_wack = rst && !m_active && wrdy;
    e_irdy = m_active && !m_drain && !m_done && (m_issued < m_ninst) && (m_out < MAX_INFLIGHT);
    check("warp_ack", o_warp_ack, e_wack);
    check("inst_rdy", o_inst_rdy, e_irdy);
    if (e_irdy) check("pc", o_pc, m_issued);
    check("done_rdy", o_done_rdy, m_done);
    check("wid", o_wid, m_wid);
    check("done_wid", o_done_wid, m_wid);
    check("bofs", o_bofs, m_bofs);
    check("aofs", o_aofs, m_aofs);
    check("err", o_err, m_err);
    obs_wack = o_warp_ack; obs_irdy = o_inst_rdy; obs_done = o_done_rdy; obs_err = o_err;
    obs_pc = int'(o_pc); obs_wid = int'(o_wid); obs_done_wid = int'(o_done_wid);
    @(posedge clk);
    e_iss = e_irdy && iack;
    last_wack = e_wack;
    if (!rst) begin
      m_active = 0; m_drain = 0; m_done = 0; m_err = 0;
      m_issued = 0; m_ninst = 0; m_out = 0; m_wid = 0; m_bofs = '0; m_aofs = '0;
    end else begin
      nout = m_out;
      if (e_iss && !cmt)      nout = m_out + 1;
      else if (cmt && !e_iss) begin
        if (m_out == 0) m_err = 1;
        else            nout = m_out - 1;
      end
      if (m_done && dack) begin
        m_active = 0; m_done = 0;
      end else if (m_drain && nout == 0) begin
        m_drain = 0; m_done = 1;
      end
      if (e_iss) begin
        m_issued++;
        if (m_issued == m_ninst) m_drain = 1;
      end
      if (e_wack) begin
        m_active = 1; m_issued = 0; m_ninst = d_ninst; m_wid = d_wid;
        m_bofs = d_bofs; m_aofs = d_aofs; m_done = (d_ninst == 0);
      end
      m_out = nout;
    end
  endtask

  initial begin
    bit have_desc;
    i_rst = 0; i_warp_rdy = 0; i_warp_wid = '0; i_warp_bofs = '0; i_warp_aofs = '0;
    i_warp_ninst = '0; i_inst_ack = 0; i_commit_dval = 0; i_done_ack = 0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_inst_rdy", obs_irdy, 0);
    check("rst_done_rdy", obs_done, 0);
    check("rst_err", obs_err, 0);
    check("rst_wid", obs_wid, 0);

    // ninst=3, commit two cycles after each issue
    d_ninst = 3; d_wid = 1; d_bofs = 16'h1234; d_aofs = 16'h5678;
    step(1, 1, 0, 0, 0); check("t1_accept", obs_wack, 1);
    step(1, 0, 1, 0, 0); check("t1_rdy0", obs_irdy, 1); check("t1_pc0", obs_pc, 0);
    step(1, 0, 1, 0, 0); check("t1_rdy1", obs_irdy, 1); check("t1_pc1", obs_pc, 1);
    step(1, 0, 1, 1, 0); check("t1_rdy2", obs_irdy, 1); check("t1_pc2", obs_pc, 2);
    step(1, 0, 1, 1, 0); check("t1_no_rdy", obs_irdy, 0);
    step(1, 0, 0, 1, 0); check("t1_not_done", obs_done, 0);
    step(1, 0, 0, 0, 1); check("t1_done", obs_done, 1); check("t1_done_wid", obs_done_wid, 1);
    step(1, 0, 0, 0, 0); check("t1_idle", obs_done, 0);

    // empty program
    d_ninst = 0; d_wid = 2;
    step(1, 1, 0, 0, 0); check("t3_accept", obs_wack, 1);
    step(1, 0, 1, 0, 1); check("t3_done", obs_done, 1); check("t3_no_rdy", obs_irdy, 0);
    step(1, 0, 1, 0, 0); check("t3_idle", obs_done, 0);

    // credit limit with no commits, then simultaneous issue+commit at MAX_INFLIGHT-1
    d_ninst = 8; d_wid = 4;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 0); check("t2_pc", obs_pc, i);
    end
    step(1, 0, 1, 0, 0); check("t2_full", obs_irdy, 0);
    step(1, 0, 1, 1, 0); check("t2_full_commit", obs_irdy, 0);
    step(1, 0, 1, 0, 0); check("t2_refill", obs_irdy, 1); check("t2_pc4", obs_pc, 4);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0); check("t2_same_rdy", obs_irdy, 1); check("t2_pc5", obs_pc, 5);
    step(1, 0, 1, 0, 0); check("t2_hold_rdy", obs_irdy, 1); check("t2_pc6", obs_pc, 6);
    for (int i = 0; i < 20; i++) step(1, 0, 1, m_out > 0, 1);

    // stray commit while idle
    step(1, 0, 0, 1, 0); check("t5_idle_commit_ack", obs_wack, 0);
    step(1, 0, 0, 0, 0); check("t5_err_set", obs_err, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); check("t5_err_sticky", obs_err, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); check("t5_err_clear", obs_err, 0);

    // reset while issuing at pc=2, then a fresh warp
    d_ninst = 8; d_wid = 5;
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0); check("t6_pc2", obs_pc, 2);
    d_ninst = 4; d_wid = 3; d_bofs = 16'hbeef; d_aofs = 16'hcafe;
    step(1, 1, 0, 0, 0);
    check("t6_rdy_low", obs_irdy, 0); check("t6_done_low", obs_done, 0); check("t6_accept", obs_wack, 1);
    step(1, 0, 1, 0, 0); check("t6_pc0", obs_pc, 0); check("t6_wid", obs_wid, 3);

    have_desc = 1;
    for (int i = 0; i < 3000; i++) begin
      bit rst, cmt;
      if (!have_desc && $urandom_range(0, 3) == 0) begin
        have_desc = 1;
        d_ninst = int'($urandom_range(0, N_INST));
        d_wid   = int'($urandom_range(0, 7));
        d_bofs  = 16'($urandom);
        d_aofs  = 16'($urandom);
      end
      rst = ($urandom_range(0, 199) != 0);
      cmt = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      step(rst, have_desc, $urandom_range(0, 3) != 0, cmt, $urandom_range(0, 2) == 0);
      if (last_wack) have_desc = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
